// File: rtl/dca_lpixm_read_arbiter.sv
// Round-robin arbiter that shares one in-order LPIXM read channel among NUM_REQ load requesters.
// An order FIFO records each grant so in-order responses are steered back to their issuer.
module dca_lpixm_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int BW_ADDR     = 32,
    parameter int BW_DATA     = 32,
    parameter int ORDER_DEPTH = 4,
    localparam int BW_IDX     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW_CNT     = $clog2(ORDER_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BW_ADDR-1:0] req_addr,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [BW_DATA-1:0]         rsp_data,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic [BW_ADDR-1:0]         m_req_addr,
    input  logic                       m_rsp_valid,
    output logic                       m_rsp_ready,
    input  logic [BW_DATA-1:0]         m_rsp_data,
    output logic [BW_CNT-1:0]          outstanding,
    output logic                       busy
);

    localparam int BW_PTR = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam logic [BW_IDX-1:0] LAST_IDX = BW_IDX'(NUM_REQ - 1);
    localparam logic [BW_PTR-1:0] PTR_MAX  = BW_PTR'(ORDER_DEPTH - 1);
    localparam logic [BW_CNT-1:0] CNT_MAX  = BW_CNT'(ORDER_DEPTH);

    logic               m_req_valid_q, m_req_valid_d;
    logic [BW_ADDR-1:0] m_req_addr_q, m_req_addr_d;
    logic [BW_IDX-1:0]  last_grant_q, last_grant_d;
    logic [BW_PTR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BW_PTR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BW_CNT-1:0]  count_q, count_d;
    logic [BW_IDX-1:0]  order_mem [ORDER_DEPTH];

    logic              slot_free;
    logic              fifo_empty;
    logic              clear_en;
    logic              capture;
    logic              pop;
    logic              grant_found;
    logic [BW_IDX-1:0] grant_idx;
    logic [BW_IDX-1:0] cand_idx;
    logic [BW_IDX-1:0] head_idx;

    assign busy        = m_req_valid_q | (count_q != '0);
    assign slot_free   = ~m_req_valid_q | m_req_ready;
    assign fifo_empty  = (count_q == '0);
    assign clear_en    = clear & ~busy;
    // No acknowledge while in reset or flushing: neither cycle could record the grant.
    assign capture     = ~rst & ~clear_en & slot_free & grant_found & (count_q < CNT_MAX);
    assign head_idx    = order_mem[rd_ptr_q];
    assign pop         = m_rsp_valid & m_rsp_ready;

    assign m_req_valid = m_req_valid_q;
    assign m_req_addr  = m_req_addr_q;
    assign rsp_data    = m_rsp_data;
    assign outstanding = count_q;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = BW_IDX'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (capture) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Response steering depends only on FIFO state, never on the request side.
    always_comb begin
        rsp_valid   = '0;
        m_rsp_ready = 1'b0;
        if (!fifo_empty) begin
            rsp_valid[head_idx] = m_rsp_valid;
            m_rsp_ready         = rsp_ready[head_idx];
        end
    end

    always_comb begin
        m_req_valid_d = m_req_valid_q;
        m_req_addr_d  = m_req_addr_q;
        last_grant_d  = last_grant_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (slot_free) begin
            m_req_valid_d = capture;
        end
        if (capture) begin
            m_req_addr_d = req_addr[grant_idx*BW_ADDR +: BW_ADDR];
            last_grant_d = grant_idx;
            wr_ptr_d     = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({capture, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (clear_en) begin
            last_grant_d = LAST_IDX;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req_valid_q <= 1'b0;
            m_req_addr_q  <= '0;
            last_grant_q  <= LAST_IDX;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            m_req_valid_q <= m_req_valid_d;
            m_req_addr_q  <= m_req_addr_d;
            last_grant_q  <= last_grant_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: order storage is not reset; an entry is only read once count_q marks it valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            order_mem[wr_ptr_q] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_dca_lpixm_read_arbiter.sv
// Directed bench for dca_lpixm_read_arbiter: grants are predicted as constants, and a
// scoreboard of issued/accepted grants checks master addresses and response steering.
module tb_dca_lpixm_read_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int BW_ADDR     = 32;
    localparam int BW_DATA     = 32;
    localparam int ORDER_DEPTH = 4;

    logic                       clk;
    logic                       rst;
    logic                       clear;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*BW_ADDR-1:0] req_addr;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [BW_DATA-1:0]         rsp_data;
    logic                       m_req_valid;
    logic                       m_req_ready;
    logic [BW_ADDR-1:0]         m_req_addr;
    logic                       m_rsp_valid;
    logic                       m_rsp_ready;
    logic [BW_DATA-1:0]         m_rsp_data;
    logic [2:0]                 outstanding;
    logic                       busy;

    dca_lpixm_read_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .BW_ADDR    (BW_ADDR),
        .BW_DATA    (BW_DATA),
        .ORDER_DEPTH(ORDER_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .m_req_valid(m_req_valid),
        .m_req_ready(m_req_ready),
        .m_req_addr (m_req_addr),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_ready(m_rsp_ready),
        .m_rsp_data (m_rsp_data),
        .outstanding(outstanding),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] addr;
    } issue_t;

    issue_t issue_q[$];   // granted, waiting for the master to accept
    int     acc_q[$];     // accepted by the master, waiting for a response
    int     exp_cnt;
    int     vectors;
    int     miscompares;

    function automatic logic [31:0] addr_of(input int i);
        return 32'((i + 1) * 256);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at posedge+1, check at the following negedge.
    task automatic step(input logic [3:0] valid, input logic mrdy, input logic do_rsp,
                        input logic [3:0] rrdy, input int exp_g);
        logic   exp_mv;
        int     h;
        issue_t e;
        @(posedge clk);
        #1;
        req_valid   = valid;
        m_req_ready = mrdy;
        m_rsp_valid = do_rsp;
        rsp_ready   = rrdy;
        m_rsp_data  = $urandom;
        #4;
        exp_mv = (issue_q.size() != 0);
        check("outstanding", 64'(outstanding), 64'(exp_cnt));
        check("busy", 64'(busy), 64'(exp_mv | (exp_cnt != 0)));
        if (do_rsp && acc_q.size() != 0) begin
            h = acc_q[0];
            check("rsp_valid", 64'(rsp_valid), 64'(4'b1 << h));
            check("m_rsp_ready", 64'(m_rsp_ready), 64'(rrdy[h[1:0]]));
            check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
            if (rrdy[h[1:0]]) begin
                void'(acc_q.pop_front());
                exp_cnt--;
            end
        end else begin
            check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
        end
        check("m_req_valid", 64'(m_req_valid), 64'(exp_mv));
        if (exp_mv) begin
            check("m_req_addr", 64'(m_req_addr), 64'(issue_q[0].addr));
            if (mrdy) begin
                e = issue_q.pop_front();
                acc_q.push_back(e.idx);
            end
        end
        check("req_ready", 64'(req_ready), (exp_g < 0) ? 64'(0) : 64'(4'b1 << exp_g));
        if (exp_g >= 0) begin
            e.idx  = exp_g;
            e.addr = addr_of(exp_g);
            issue_q.push_back(e);
            exp_cnt++;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 16 && exp_cnt > 0; n++) begin
            step(4'b0000, 1'b1, acc_q.size() != 0, 4'hf, -1);
        end
        step(4'b0000, 1'b1, 1'b0, 4'hf, -1);
        check("drained_outstanding", 64'(outstanding), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 0;
        rst         = 1'b1;
        clear       = 1'b0;
        req_valid   = '0;
        rsp_ready   = '0;
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*BW_ADDR +: BW_ADDR] = addr_of(i);

        // Reset release with no requests: everything idle.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #4;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_m_req_valid", 64'(m_req_valid), 64'(0));
        check("rst_m_req_addr", 64'(m_req_addr), 64'(0));
        check("rst_m_rsp_ready", 64'(m_rsp_ready), 64'(0));
        check("rst_outstanding", 64'(outstanding), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        // Stray master response with the FIFO empty is never accepted.
        m_rsp_valid = 1'b1;
        rsp_ready   = 4'hf;
        #1;
        check("stray_m_rsp_ready", 64'(m_rsp_ready), 64'(0));
        check("stray_rsp_valid", 64'(rsp_valid), 64'(0));
        m_rsp_valid = 1'b0;

        // Single request from requester 0, then master stalled for 5 cycles.
        step(4'b0001, 1'b0, 1'b0, 4'hf, 0);
        step(4'b0000, 1'b0, 1'b0, 4'hf, -1);
        check("first_outstanding", 64'(outstanding), 64'(1));
        repeat (5) step(4'b1111, 1'b0, 1'b0, 4'hf, -1);
        step(4'b1111, 1'b1, 1'b0, 4'hf, 1);

        // Continuous round robin with immediate responses.
        for (int k = 0; k < 6; k++) step(4'b1111, 1'b1, 1'b1, 4'hf, (k + 2) % 4);
        drain();

        // Fill the order FIFO with no responses, then pop one.
        step(4'b1111, 1'b1, 1'b0, 4'hf, 0);
        step(4'b1111, 1'b1, 1'b0, 4'hf, 1);
        step(4'b1111, 1'b1, 1'b0, 4'hf, 2);
        step(4'b1111, 1'b1, 1'b0, 4'hf, 3);
        repeat (3) step(4'b1111, 1'b1, 1'b0, 4'hf, -1);
        check("full_outstanding", 64'(outstanding), 64'(4));
        step(4'b1111, 1'b1, 1'b1, 4'hf, -1);
        step(4'b1111, 1'b1, 1'b0, 4'hf, 0);
        drain();

        // In-order stall: head (requester 1) not ready while requester 2 is.
        step(4'b1111, 1'b1, 1'b0, 4'hf, 1);
        step(4'b1111, 1'b1, 1'b0, 4'hf, 2);
        step(4'b0000, 1'b1, 1'b0, 4'hf, -1);
        repeat (2) step(4'b0000, 1'b1, 1'b1, 4'b0100, -1);
        step(4'b0000, 1'b1, 1'b1, 4'b0110, -1);
        step(4'b0000, 1'b1, 1'b1, 4'b0100, -1);
        drain();

        // clear while busy with two outstanding: ignored (pointers and last grant kept).
        step(4'b1111, 1'b1, 1'b0, 4'hf, 3);
        step(4'b1111, 1'b1, 1'b0, 4'hf, 0);
        step(4'b0000, 1'b1, 1'b0, 4'hf, -1);
        clear = 1'b1;
        step(4'b0000, 1'b1, 1'b0, 4'hf, -1);
        clear = 1'b0;
        check("clear_busy_outstanding", 64'(outstanding), 64'(2));
        step(4'b1111, 1'b1, 1'b0, 4'hf, 1);
        drain();

        // clear while idle restarts the round robin at requester 0.
        clear = 1'b1;
        step(4'b0000, 1'b1, 1'b0, 4'hf, -1);
        clear = 1'b0;
        step(4'b1111, 1'b1, 1'b0, 4'hf, 0);

        // Asynchronous reset in the middle of a burst.
        step(4'b1111, 1'b1, 1'b0, 4'hf, 1);
        m_rsp_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_m_req_valid", 64'(m_req_valid), 64'(0));
        check("midrst_m_req_addr", 64'(m_req_addr), 64'(0));
        check("midrst_m_rsp_ready", 64'(m_rsp_ready), 64'(0));
        check("midrst_outstanding", 64'(outstanding), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        req_valid   = '0;
        m_rsp_valid = 1'b0;
        issue_q.delete();
        acc_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b1111, 1'b1, 1'b0, 4'hf, 0);
        step(4'b0000, 1'b1, 1'b0, 4'hf, -1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dca_lpixm_read_arbiter.md
# dca_lpixm_read_arbiter

Shares a single LPIXM read channel (request/response, in-order) between NUM_REQ DCA load requesters. It grants requests round-robin, registers the winning address onto the master request channel, and records each grant in an order FIFO. In-order responses are then steered back to the requester that issued them. It sits between the per-operand load units of the DCA matrix engine and the LPIXM-to-AXI bridge, and bounds total outstanding reads to ORDER_DEPTH.

## Interface

Parameters:
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- BW_ADDR, default 32: address width.
- BW_DATA, default 32: response data width.
- ORDER_DEPTH, default 4: maximum accepted reads not yet responded; legal range 1..16.
- Derived: BW_IDX = max(1, clog2(NUM_REQ)); BW_CNT = clog2(ORDER_DEPTH+1).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush; honoured only when busy==0, otherwise ignored.
- req_valid  input  NUM_REQ  per-requester read request.
- req_addr  input  NUM_REQ*BW_ADDR  flattened addresses; requester i uses bits [i*BW_ADDR +: BW_ADDR].
- req_ready  output  NUM_REQ  one-hot acceptance pulse.
- rsp_valid  output  NUM_REQ  one-hot response valid.
- rsp_ready  input  NUM_REQ  per-requester response ready.
- rsp_data  output  BW_DATA  shared response data; pass-through of m_rsp_data.
- m_req_valid  output  1  master request valid (registered).
- m_req_ready  input  1  master request ready.
- m_req_addr  output  BW_ADDR  master request address (registered).
- m_rsp_valid  input  1  master response valid.
- m_rsp_ready  output  1  master response ready.
- m_rsp_data  input  BW_DATA  master response data.
- outstanding  output  BW_CNT  order-FIFO occupancy.
- busy  output  1  m_req_valid | (outstanding != 0).

## Operation

- Issue slot: a one-entry register {m_req_valid, m_req_addr}. The slot is "free" when m_req_valid==0 or (m_req_valid & m_req_ready).
- Capture condition: slot free AND any req_valid AND outstanding < ORDER_DEPTH. The FIFO-full test uses the registered count; a pop in the same cycle does not unblock a push.
- On capture:
  - winner g = first requester with req_valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[g]=1 (combinational, same cycle); all other req_ready bits are 0.
  - Next edge: m_req_addr<=req_addr[g], m_req_valid<=1, last_grant<=g, g pushed into the order FIFO.
- Slot free with no capture: next edge m_req_valid<=0. m_req_addr holds its value.
- While m_req_valid & ~m_req_ready: m_req_valid and m_req_addr are stable, and req_ready is all 0.
- Response routing, FIFO non-empty with head index h:
  - rsp_valid[h] = m_rsp_valid.
  - m_rsp_ready = rsp_ready[h].
  - A handshake pops the head.
- FIFO empty: m_rsp_ready=0 and rsp_valid=0. A stray m_rsp_valid is never accepted.
- A simultaneous push and pop leaves outstanding unchanged. Indices wrap mod ORDER_DEPTH.
- clear while busy==0: last_grant<=NUM_REQ-1 and FIFO pointers reset. clear while busy==1: no effect.
- rst asserted mid-transfer: state drops immediately, and in-flight master transactions are abandoned. The system must reset the bridge together with this block.

## Timing

- Reset values:
  - m_req_valid=0, m_req_addr=0, last_grant=NUM_REQ-1, FIFO pointers and count =0.
  - Outputs: req_ready=0, rsp_valid=0, m_rsp_ready=0, outstanding=0, busy=0.
- Request latency: req_ready pulse in cycle T, m_req_valid high from T+1.
- Back-to-back: with m_req_ready held high, one capture per cycle. Sustained throughput is 1 request/cycle until the FIFO fills.
- Response path is purely combinational (zero latency): m_rsp_valid→rsp_valid and rsp_ready→m_rsp_ready. It contains no combinational path to the request side.
- outstanding increments in the cycle after capture and decrements in the cycle after the response handshake.

## Test plan

- Reset release, all req_valid=0: all outputs 0, busy=0; then req_valid=4'b0001, addr0=0x100 → req_ready=0001 at T, m_req_valid=1 with m_req_addr=0x100 at T+1, outstanding=1 at T+1.
- All four requesters valid continuously, m_req_ready=1, responses returned immediately: grant order 0,1,2,3,0,1,...; each rsp_valid one-hot matches the issuing order.
- ORDER_DEPTH=4, no responses: exactly 4 captures, then req_ready stays 0 and outstanding=4. One response pops: the next capture occurs one cycle after the pop, not the same cycle.
- m_req_ready=0 for 5 cycles with req_valid=1111: m_req_addr stable, req_ready=0 throughout; the capture resumes the cycle m_req_ready rises.
- Head requester rsp_ready=0 while a later requester is ready: m_rsp_ready=0 and no data reaches the later requester (in-order stall). m_rsp_valid with FIFO empty → m_rsp_ready=0.
- clear pulsed with outstanding=2: ignored, and counts are unchanged. rst pulsed mid-burst: all outputs 0 asynchronously, and the first grant after release goes to requester 0.
